// File: rtl/common_pseudo_lru_victim_alloc.sv
// common_pseudo_lru_victim_alloc: client controller that drives pseudo-LRU touches and hands out victim ways.
module common_pseudo_lru_victim_alloc #(
   parameter int SUBJECT_COUNT_LOG2 = 3,
   parameter int PICK_STALL_MAX = 4,
   localparam int N = 1 << SUBJECT_COUNT_LOG2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         hit_valid_i,
   input  logic [N-1:0] hit_way_i,
   input  logic [N-1:0] way_avail_i,
   input  logic [N-1:0] way_valid_i,
   input  logic         alloc_req_valid_i,
   output logic         alloc_req_ready_o,
   output logic         alloc_resp_valid_o,
   input  logic         alloc_resp_ready_i,
   output logic [N-1:0] alloc_way_o,
   output logic         alloc_none_o,
   output logic [N-1:0] lru_waddr_o,
   output logic         lru_wen_o,
   output logic [N-1:0] lru_dvalid_o,
   input  logic [N-1:0] lru_qaddr_i
);
   typedef enum logic [1:0] {IDLE, PICK, RESP} state_e;
   localparam logic [N-1:0] LSB = N'(1);
   state_e       state_q;
   logic [N-1:0] pend_q, waddr_q, way_q;
   logic         wen_q, none_q;
   logic [3:0]   stall_q;
   logic         hit_ok, sample;
   logic [N-1:0] free, hint, victim;
   always_comb begin
      hit_ok = hit_valid_i & (|hit_way_i);
      free   = way_avail_i & ~way_valid_i;
      hint   = lru_qaddr_i & way_avail_i;
      // x & (~x + 1) isolates the lowest set bit; yields 0 when nothing is available
      victim = (|free) ? (free & (~free + LSB)) :
               (|hint) ? hint : (way_avail_i & (~way_avail_i + LSB));
      sample = (~|pend_q & ~wen_q) | (stall_q == 4'(PICK_STALL_MAX));
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pend_q  <= '0;
         waddr_q <= '0;
         wen_q   <= 1'b0;
         way_q   <= '0;
         none_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         wen_q   <= hit_ok | (|pend_q);
         waddr_q <= hit_ok ? hit_way_i : pend_q;
         // hits win the touch port; a deferred allocation touch waits behind them
         if (state_q == RESP && alloc_resp_ready_i && !none_q) pend_q <= way_q;
         else if (!hit_ok) pend_q <= '0;
         case (state_q)
            IDLE: if (alloc_req_valid_i) begin
               state_q <= PICK;
               stall_q <= '0;
            end
            PICK: if (sample) begin
               way_q   <= victim;
               none_q  <= ~|way_avail_i;
               state_q <= RESP;
            end else stall_q <= stall_q + 4'd1;
            RESP: if (alloc_resp_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign alloc_req_ready_o  = state_q == IDLE;
   assign alloc_resp_valid_o = state_q == RESP;
   assign alloc_way_o        = way_q;
   assign alloc_none_o       = none_q;
   assign lru_waddr_o        = waddr_q;
   assign lru_wen_o          = wen_q;
   assign lru_dvalid_o       = way_avail_i;
endmodule

// File: tb/tb_common_pseudo_lru_victim_alloc.sv
// tb_common_pseudo_lru_victim_alloc: directed stimulus with a queue scoreboard for victim results and touches.
module tb_common_pseudo_lru_victim_alloc;
   logic       clk_i = 1'b0, rst_ni = 1'b0;
   logic       hit_valid_i = 1'b0, alloc_req_valid_i = 1'b0, alloc_resp_ready_i = 1'b0;
   logic [7:0] hit_way_i = '0, way_avail_i = 8'hFF, way_valid_i = 8'hFF, lru_qaddr_i = 8'h01;
   logic       alloc_req_ready_o, alloc_resp_valid_o, alloc_none_o, lru_wen_o;
   logic [7:0] alloc_way_o, lru_waddr_o, lru_dvalid_o;

   common_pseudo_lru_victim_alloc #(.SUBJECT_COUNT_LOG2(3), .PICK_STALL_MAX(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .hit_valid_i(hit_valid_i), .hit_way_i(hit_way_i),
      .way_avail_i(way_avail_i), .way_valid_i(way_valid_i), .alloc_req_valid_i(alloc_req_valid_i),
      .alloc_req_ready_o(alloc_req_ready_o), .alloc_resp_valid_o(alloc_resp_valid_o),
      .alloc_resp_ready_i(alloc_resp_ready_i), .alloc_way_o(alloc_way_o), .alloc_none_o(alloc_none_o),
      .lru_waddr_o(lru_waddr_o), .lru_wen_o(lru_wen_o), .lru_dvalid_o(lru_dvalid_o), .lru_qaddr_i(lru_qaddr_i));

   always #5 clk_i = ~clk_i;

   typedef struct {logic [7:0] way; logic none; int lat;} resp_t;
   resp_t      rq[$];
   logic [7:0] tq[$];
   int n = 0, fails = 0, cyc = 0, acc_cyc = 0, rise_cyc = 0;
   logic prev_v = 1'b0;

   always @(posedge clk_i) cyc++;

   task automatic tick;
      @(posedge clk_i);
      #2;
   endtask

   always @(negedge clk_i) begin
      if (!rst_ni) prev_v = 1'b0;
      else begin
         if (alloc_resp_valid_o && !prev_v) rise_cyc = cyc;
         prev_v = alloc_resp_valid_o;
         n++;
         if (lru_dvalid_o !== way_avail_i) begin
            fails++;
            $display("FAIL dvalid: got %h want %h", lru_dvalid_o, way_avail_i);
         end
         if (alloc_resp_valid_o && alloc_resp_ready_i) begin
            n++;
            if (rq.size() == 0) begin
               fails++;
               $display("FAIL resp_unexpected: got way %h none %b, want no response", alloc_way_o, alloc_none_o);
            end else begin
               resp_t e;
               e = rq.pop_front();
               if (alloc_way_o !== e.way || alloc_none_o !== e.none) begin
                  fails++;
                  $display("FAIL resp: got way %h none %b, want way %h none %b", alloc_way_o, alloc_none_o, e.way, e.none);
               end
               n++;
               if (rise_cyc - acc_cyc != e.lat) begin
                  fails++;
                  $display("FAIL resp_latency: got %0d want %0d", rise_cyc - acc_cyc, e.lat);
               end
            end
         end
         if (lru_wen_o) begin
            n++;
            if (tq.size() == 0) begin
               fails++;
               $display("FAIL touch_unexpected: got waddr %h, want no touch", lru_waddr_o);
            end else begin
               logic [7:0] t;
               t = tq.pop_front();
               if (lru_waddr_o !== t) begin
                  fails++;
                  $display("FAIL touch: got %h want %h", lru_waddr_o, t);
               end
            end
         end
      end
   end

   task automatic alloc(input logic [7:0] vv, va, q, ew, input logic en, input int el, hold, input logic touch);
      int k;
      way_valid_i = vv; way_avail_i = va; lru_qaddr_i = q; alloc_req_valid_i = 1'b1;
      k = 0;
      while (!alloc_req_ready_o && k < 20) begin tick(); k++; end
      if (!alloc_req_ready_o) begin
         n++; fails++;
         $display("FAIL req_ready_timeout: got 0 want 1");
      end
      tick();
      alloc_req_valid_i = 1'b0;
      acc_cyc = cyc;
      rq.push_back('{ew, en, el});
      alloc_resp_ready_i = (hold == 0);
      k = 0;
      while (!alloc_resp_valid_o && k < 20) begin tick(); k++; end
      if (!alloc_resp_valid_o) begin
         n++; fails++;
         $display("FAIL resp_valid_timeout: got 0 want 1");
      end
      if (hold > 0) begin
         way_avail_i = 8'h00; way_valid_i = 8'h00; lru_qaddr_i = 8'h01;
         repeat (hold) tick();
         alloc_resp_ready_i = 1'b1;
      end
      tick();
      alloc_resp_ready_i = 1'b0;
      if (touch) tq.push_back(ew);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12;
      n++;
      if ({alloc_req_ready_o, alloc_resp_valid_o, lru_wen_o, lru_waddr_o, alloc_way_o, alloc_none_o} !== {3'b100, 8'h00, 8'h00, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: got rdy %b vld %b wen %b waddr %h way %h none %b", alloc_req_ready_o,
                  alloc_resp_valid_o, lru_wen_o, lru_waddr_o, alloc_way_o, alloc_none_o);
      end
      rst_ni = 1'b1;
      repeat (3) tick();
      alloc(8'hFF, 8'hFF, 8'h01, 8'h01, 1'b0, 1, 0, 1'b1);
      repeat (4) tick();
      alloc(8'hF3, 8'hFF, 8'h01, 8'h04, 1'b0, 1, 0, 1'b1);
      repeat (4) tick();
      alloc(8'hFF, 8'h00, 8'h01, 8'h00, 1'b1, 1, 0, 1'b0);
      repeat (4) tick();
      alloc(8'hFF, 8'h0F, 8'h80, 8'h01, 1'b0, 1, 0, 1'b1);
      repeat (4) tick();
      alloc(8'hFF, 8'hF0, 8'h40, 8'h40, 1'b0, 1, 0, 1'b1);
      repeat (4) tick();
      alloc(8'hFF, 8'hFF, 8'h10, 8'h10, 1'b0, 1, 2, 1'b1);
      repeat (4) tick();
      // hit collides with the deferred allocation touch: hit first, then the pending way
      alloc(8'hFF, 8'hFF, 8'h02, 8'h02, 1'b0, 1, 0, 1'b0);
      hit_valid_i = 1'b1; hit_way_i = 8'h20;
      tq.push_back(8'h20); tq.push_back(8'h02);
      tick();
      hit_valid_i = 1'b0;
      repeat (4) tick();
      fork
         alloc(8'hFF, 8'hFF, 8'h08, 8'h08, 1'b0, 5, 0, 1'b0);
         begin
            repeat (7) begin
               hit_valid_i = 1'b1; hit_way_i = 8'h10; tq.push_back(8'h10);
               tick();
            end
            hit_valid_i = 1'b0;
         end
      join
      tq.push_back(8'h08);
      repeat (4) tick();
      hit_valid_i = 1'b1; hit_way_i = 8'h00;
      tick();
      hit_way_i = 8'h81; tq.push_back(8'h81);
      tick();
      hit_valid_i = 1'b0;
      repeat (4) tick();
      way_valid_i = 8'hFF; way_avail_i = 8'hFF; lru_qaddr_i = 8'h01; alloc_req_valid_i = 1'b1;
      tick();
      alloc_req_valid_i = 1'b0;
      for (int k = 0; k < 20 && !alloc_resp_valid_o; k++) tick();
      n++;
      if (!alloc_resp_valid_o) begin
         fails++;
         $display("FAIL resp_valid_timeout_before_reset: got 0 want 1");
      end
      rst_ni = 1'b0;
      #1;
      n++;
      if ({alloc_resp_valid_o, lru_wen_o, alloc_req_ready_o} !== 3'b001) begin
         fails++;
         $display("FAIL async_reset: got vld %b wen %b rdy %b want 0 0 1", alloc_resp_valid_o, lru_wen_o, alloc_req_ready_o);
      end
      rq.delete();
      repeat (2) tick();
      rst_ni = 1'b1;
      alloc_resp_ready_i = 1'b1;
      repeat (6) tick();
      alloc_resp_ready_i = 1'b0;
      n++;
      if (rq.size() != 0 || tq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d resp %0d touch outstanding, want 0 0", rq.size(), tq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule
